// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Quotient returned on divide by zero; sliced down to the unit width.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/exec_muldiv_if.sv
// Start/busy/done handshake between the control unit and the mul/div unit.
interface exec_muldiv_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             divZero;

  modport master (
    output start, op, opA, opB,
    input  busy, done, result, divZero
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, result, divZero
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_e                op_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Mul: {hi, multiplier} register; div: {remainder, dividend/quotient} register.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, mcand_i} : '0);
    // Shifted remainder keeps the bit pushed out of the top so it never overflows.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, divisor_i};
    if (!is_div(op_i)) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide unit beside the ALU; one result bit per cycle.
module exec_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  exec_muldiv_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 dz_q, dz_d;

  logic [2*WIDTH-1:0]   step_acc;
  op_e                  req_op;
  logic [WIDTH-1:0]     step_sel;

  assign req_op = op_e'(bus.op);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .mcand_i   (a_q),
    .divisor_i (b_q),
    .acc_o     (step_acc)
  );

  // Low half for MUL/DIVU (product low / quotient), high half for MULHU/REMU.
  always_comb begin
    step_sel = (op_q == OP_MUL || op_q == OP_DIVU) ? step_acc[WIDTH-1:0]
                                                   : step_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state: accept in IDLE/DONE, iterate in RUN, load result entering DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (bus.start) begin
          op_d  = req_op;
          a_d   = bus.opA;
          b_d   = bus.opB;
          cnt_d = '0;
          if (is_div(req_op) && bus.opB == '0) begin
            acc_d    = '0;
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = (req_op == OP_DIVU) ? DIV_ZERO_QUOT[WIDTH-1:0] : bus.opA;
            dz_d     = 1'b1;
          end else begin
            // Cleared upper half; lower half seeded with multiplier or dividend.
            acc_d   = is_div(req_op) ? {{WIDTH{1'b0}}, bus.opA} : {{WIDTH{1'b0}}, bus.opB};
            state_d = RUN;
            busy_d  = 1'b1;
            dz_d    = 1'b0;
          end
        end
      end
      RUN: begin
        acc_d = step_acc;
        if (cnt_q == LastCnt) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = step_sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.divZero = dz_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed bench for exec_muldiv: expected values computed by hand.
module tb_exec_muldiv;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  exec_muldiv_if #(.WIDTH(16)) bus ();

  exec_muldiv #(
    .WIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
  endtask

  // Counts edges from the accept edge up to and including the one raising done.
  task automatic wait_done(output int lat, output bit busy_seen);
    lat       = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res, input bit exp_dz,
                        input int exp_lat);
    int lat;
    bit bs;
    issue(op, a, b);
    wait_done(lat, bs);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " divZero"}, bus.divZero, exp_dz);
    check({tag, " busy seen"}, bs, (exp_lat > 1));
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, bus.done, 1'b0);
    check({tag, " result held"}, bus.result, exp_res);
  endtask

  initial begin
    int lat;
    bit bs;
    int pulses;
    int done_at;
    logic [15:0] res_at;

    n_checks  = 0;
    n_errors  = 0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = '0;
    bus.opB   = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 16'h0000);
    check("reset divZero", bus.divZero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul 3*5", 2'b00, 16'h0003, 16'h0005, 16'h000F, 1'b0, 17);

    // MUL then MULHU issued during the MUL's DONE cycle.
    issue(2'b00, 16'hFFFF, 16'hFFFF);
    wait_done(lat, bs);
    check("mul ffff latency", lat, 17);
    check("mul ffff result", bus.result, 16'h0001);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.opA   = 16'hFFFF;
    bus.opB   = 16'hFFFF;
    wait_done(lat, bs);
    check("mulhu b2b latency", lat, 17);
    check("mulhu b2b result", bus.result, 16'hFFFE);
    check("mulhu b2b busy", bs, 1'b1);

    run_op("divu 100/7", 2'b10, 16'h0064, 16'h0007, 16'h000E, 1'b0, 17);
    run_op("remu 100/7", 2'b11, 16'h0064, 16'h0007, 16'h0002, 1'b0, 17);
    run_op("divu /0", 2'b10, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1);
    run_op("remu /0", 2'b11, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1);
    run_op("divu ffff/1", 2'b10, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17);

    // Second start and operand changes during RUN must be ignored.
    issue(2'b00, 16'h0007, 16'h0009);
    pulses  = 0;
    done_at = 0;
    res_at  = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (i == 5) begin
        bus.start = 1'b1;
        bus.opA   = 16'h0100;
        bus.opB   = 16'h0022;
      end
      if (i == 6) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        done_at = i;
        res_at  = bus.result;
      end
    end
    check("ignore start pulses", pulses, 1);
    check("ignore start latency", done_at, 17);
    check("ignore start result", res_at, 16'h003F);

    // Asynchronous reset in the middle of RUN.
    issue(2'b00, 16'h0005, 16'h0005);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
    end
    check("pre-reset busy", bus.busy, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async rst busy", bus.busy, 1'b0);
    check("async rst done", bus.done, 1'b0);
    check("async rst result", bus.result, 16'h0000);
    check("async rst divZero", bus.divZero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) pulses++;
    end
    check("no done after rst", pulses, 0);
    run_op("mul 2*2", 2'b00, 16'h0002, 16'h0002, 16'h0004, 1'b0, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
